gpio_output: RTL and testbench
==============================

Name: gpio_output

Overview:
Digital-output driver for the PLC I/O subsystem. Holds the DO image register and accepts bus-side write/set/clear/toggle operations. Supports a shared one-shot pulse timer and forces outputs to a safe pattern on a watchdog timeout. All outputs are registered and drive the pad-side gpio_o lines directly.

Parameters:
WIDTH, 32, number of output channels
WDT_W, 16, watchdog counter/timeout width
PULSE_W, 16, pulse timer/length width

Ports:
clk  input  1  system clock
rst  input  1  synchronous reset, active-high
wr_en  input  1  apply wr_op to the DO image this cycle
wr_op  input  2  00 write, 01 set (OR), 10 clear (AND-NOT), 11 toggle (XOR)
wr_data  input  WIDTH  operand for wr_op
pulse_start  input  1  start a one-shot pulse
pulse_mask  input  WIDTH  channels driven high during the pulse
pulse_len  input  PULSE_W  pulse length in cycles; 0 means ignore
wdt_timeout  input  WDT_W  watchdog period in cycles; 0 disables the watchdog
wdt_kick  input  1  restart the watchdog
wdt_clear  input  1  leave TRIPPED, or act as a kick when in RUN
safe_value  input  WIDTH  pattern driven while TRIPPED
gpio_o  output  WIDTH  registered pad outputs
do_status  output  WIDTH  DO image readback
pulse_busy  output  1  pulse timer running
wdt_tripped  output  1  high in state TRIPPED

Behaviour:
- Reset (rst=1 at a clk edge): DO image=0, gpio_o=0, do_status=0, pulse mask=0, pulse timer=0, pulse_busy=0, wdt counter=0, state=RUN, wdt_tripped=0. Reset mid-pulse or while TRIPPED aborts the pulse or trip immediately.
- All registers update on the clk edge. gpio_o, do_status, pulse_busy and wdt_tripped are computed from next-state values, so each input takes effect on the edge where it is sampled (1-cycle latency).
- DO image update on wr_en: 00 img=wr_data; 01 img|=wr_data; 10 img&=~wr_data; 11 img^=wr_data. wr_en is accepted in both states; do_status always shows the image.
- States are RUN and TRIPPED.
- RUN output: gpio_o = img | pulse_mask_r, where pulse_mask_r is the registered pulse mask.
- TRIPPED output: gpio_o = safe_value, sampled each cycle, so a change in safe_value appears 1 cycle later.
- Pulse, start: pulse_start with pulse_len=L≠0 in RUN loads timer=L and pulse_mask_r=pulse_mask.
- Pulse, run and end: the timer decrements each later edge. On the edge where timer==1, pulse_mask_r clears and timer goes to 0. gpio_o is therefore high on the mask for exactly L cycles.
- pulse_busy = (timer≠0).
- pulse_start while busy restarts with the new mask and length.
- pulse_start with L=0, or while TRIPPED, is ignored.
- Pulse and write on the same edge: both are applied. Pulsed channels OR with the image; the image itself is unchanged by the pulse.
- Watchdog in RUN with wdt_timeout=T≠0:
  - kick or clear sets cnt=0;
  - otherwise, if cnt==T-1, go to TRIPPED;
  - otherwise cnt+=1.
  - wdt_tripped therefore rises T edges after the last kick edge if there are no further kicks. A kick on the would-be-trip edge prevents the trip.
- T=0: cnt is held at 0 and no trip occurs. Changing T mid-count compares against the new value. If cnt ≥ new T-1, the trip happens on the next edge without a kick.
- Entering TRIPPED: pulse aborted (mask=0, timer=0), cnt held, gpio_o=safe_value on the same edge.
- In TRIPPED: wdt_kick has no effect. wdt_clear returns to RUN with cnt=0, and gpio_o=img on that edge. The image is retained, including writes made while tripped.
- Widths: the pulse timer and wdt counter never wrap. The timer stops at 0; cnt stops on the trip.

Test Plan:
1. Reset, then write 0x0000_00F0, set 0x0000_0001, clear 0x0000_0010, toggle 0x0000_0003 on consecutive cycles → gpio_o/do_status read 0xF0, 0xF1, 0xE1, 0xE2, each one edge after the op.
2. img=0, pulse_start with mask 0x5 and len 3 → gpio_o=0x5 for exactly 3 cycles, then 0. pulse_busy high for the same 3 cycles. A second start at cycle 1 with len 4 extends the pulse to 5 cycles total.
3. T=10, kick once, then no kicks → wdt_tripped rises on the 10th edge after the kick, and gpio_o=safe_value=0xA5A5_A5A5 on that edge. A pulse that is active at that edge is cancelled.
4. T=10, kick on the 10th edge (the would-be-trip edge) → no trip. Then a write of 0x3 during TRIPPED, followed by wdt_clear → do_status=0x3 throughout, and gpio_o=0x3 on the clear edge.
5. T=0 held for 1000 cycles with no kicks → wdt_tripped stays 0. pulse_start with len 0 → pulse_busy stays 0 and gpio_o is unchanged.
6. Assert rst for 1 cycle mid-pulse while the image is nonzero → all outputs are 0 on the next edge and state is RUN.

Source files
------------

// File: rtl/gpio_output.sv
// gpio_output: PLC digital-output driver with DO image, one-shot pulse and watchdog safe state
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   wr_en/wr_op/wr_data  image write (00 write, 01 set, 10 clear, 11 toggle)
//   pulse_start/pulse_mask/pulse_len  one-shot pulse request (len 0 ignored)
//   wdt_timeout/wdt_kick/wdt_clear    watchdog period (0 disables), kick, clear
//   safe_value      pattern driven while tripped
//   gpio_o          registered pad outputs
//   do_status       DO image readback
//   pulse_busy      pulse timer running
//   wdt_tripped     watchdog tripped
module gpio_output #(
    parameter int WIDTH   = 32,
    parameter int WDT_W   = 16,
    parameter int PULSE_W = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               wr_en,
    input  logic [1:0]         wr_op,
    input  logic [WIDTH-1:0]   wr_data,
    input  logic               pulse_start,
    input  logic [WIDTH-1:0]   pulse_mask,
    input  logic [PULSE_W-1:0] pulse_len,
    input  logic [WDT_W-1:0]   wdt_timeout,
    input  logic               wdt_kick,
    input  logic               wdt_clear,
    input  logic [WIDTH-1:0]   safe_value,
    output logic [WIDTH-1:0]   gpio_o,
    output logic [WIDTH-1:0]   do_status,
    output logic               pulse_busy,
    output logic               wdt_tripped
);
    typedef enum logic {RUN, TRIPPED} state_t;
    state_t st, st_n;
    logic [WIDTH-1:0] img, img_n, mask, mask_n, gpio_n;
    logic [PULSE_W-1:0] timer, timer_n;
    logic [WDT_W-1:0] cnt, cnt_n;
    logic trip, start;
    always_comb begin
        img_n = !wr_en ? img :
                wr_op == 2'b00 ? wr_data :
                wr_op == 2'b01 ? (img | wr_data) :
                wr_op == 2'b10 ? (img & ~wr_data) : (img ^ wr_data);
        // >= rather than == so that lowering the timeout below the running count trips at once
        trip = st == RUN && wdt_timeout != '0 && !wdt_kick && !wdt_clear && cnt >= wdt_timeout - WDT_W'(1);
        st_n = st == RUN ? (trip ? TRIPPED : RUN) : (wdt_clear ? RUN : TRIPPED);
        cnt_n = (st == RUN && (wdt_timeout == '0 || wdt_kick || wdt_clear)) || (st == TRIPPED && wdt_clear) ? '0 :
                (st == RUN && !trip) ? cnt + WDT_W'(1) : cnt;
        start = st == RUN && pulse_start && pulse_len != '0;
        timer_n = st_n == TRIPPED ? '0 : start ? pulse_len : timer != '0 ? timer - PULSE_W'(1) : '0;
        mask_n = st_n == TRIPPED ? '0 : start ? pulse_mask : timer > PULSE_W'(1) ? mask : '0;
        gpio_n = st_n == TRIPPED ? safe_value : (img_n | mask_n);
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            st     <= RUN;
            img    <= '0;
            mask   <= '0;
            timer  <= '0;
            cnt    <= '0;
            gpio_o <= '0;
        end else begin
            st     <= st_n;
            img    <= img_n;
            mask   <= mask_n;
            timer  <= timer_n;
            cnt    <= cnt_n;
            gpio_o <= gpio_n;
        end
    end
    assign do_status   = img;
    assign pulse_busy  = timer != '0;
    assign wdt_tripped = st == TRIPPED;
endmodule

// File: tb/tb_gpio_output.sv
// tb_gpio_output: directed self-checking bench for gpio_output
module tb_gpio_output;
    logic        clk = 1'b0;
    logic        rst, wr_en, pulse_start, wdt_kick, wdt_clear;
    logic [1:0]  wr_op;
    logic [31:0] wr_data, pulse_mask, safe_value, gpio_o, do_status;
    logic [15:0] pulse_len, wdt_timeout;
    logic        pulse_busy, wdt_tripped;
    int          passed = 0, total = 0;
    logic        any_trip;

    gpio_output dut (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_op(wr_op), .wr_data(wr_data),
        .pulse_start(pulse_start), .pulse_mask(pulse_mask), .pulse_len(pulse_len),
        .wdt_timeout(wdt_timeout), .wdt_kick(wdt_kick), .wdt_clear(wdt_clear),
        .safe_value(safe_value), .gpio_o(gpio_o), .do_status(do_status),
        .pulse_busy(pulse_busy), .wdt_tripped(wdt_tripped)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic wr(input logic [1:0] op, input logic [31:0] d);
        wr_en = 1'b1; wr_op = op; wr_data = d;
        tick();
        wr_en = 1'b0;
    endtask

    initial begin
        rst = 1'b1; wr_en = 0; wr_op = 0; wr_data = 0; pulse_start = 0; pulse_mask = 0;
        pulse_len = 0; wdt_timeout = 0; wdt_kick = 0; wdt_clear = 0; safe_value = 32'hA5A5_A5A5;
        tick();
        tick();
        rst = 1'b0;
        chk("rst_gpio", gpio_o, 0);
        chk("rst_status", do_status, 0);
        chk("rst_busy", {31'd0, pulse_busy}, 0);
        chk("rst_trip", {31'd0, wdt_tripped}, 0);

        // image operations
        wr(2'b00, 32'h0000_00F0); chk("write", gpio_o, 32'hF0); chk("write_st", do_status, 32'hF0);
        wr(2'b01, 32'h0000_0001); chk("set", gpio_o, 32'hF1);   chk("set_st", do_status, 32'hF1);
        wr(2'b10, 32'h0000_0010); chk("clear", gpio_o, 32'hE1); chk("clear_st", do_status, 32'hE1);
        wr(2'b11, 32'h0000_0003); chk("toggle", gpio_o, 32'hE2); chk("toggle_st", do_status, 32'hE2);

        // pulse of length 3
        wr(2'b00, 32'h0);
        pulse_start = 1; pulse_mask = 32'h5; pulse_len = 3;
        tick(); pulse_start = 0;
        chk("p3_c1", gpio_o, 32'h5); chk("p3_busy1", {31'd0, pulse_busy}, 1);
        tick(); chk("p3_c2", gpio_o, 32'h5);
        tick(); chk("p3_c3", gpio_o, 32'h5); chk("p3_busy3", {31'd0, pulse_busy}, 1);
        tick(); chk("p3_end", gpio_o, 32'h0); chk("p3_busy_end", {31'd0, pulse_busy}, 0);

        // restart at cycle 1 with length 4 -> 5 cycles total
        pulse_start = 1; pulse_len = 3;
        tick(); chk("px_c1", gpio_o, 32'h5);
        pulse_len = 4;
        tick(); pulse_start = 0; chk("px_c2", gpio_o, 32'h5);
        tick(); chk("px_c3", gpio_o, 32'h5);
        tick(); chk("px_c4", gpio_o, 32'h5);
        tick(); chk("px_c5", gpio_o, 32'h5); chk("px_busy5", {31'd0, pulse_busy}, 1);
        tick(); chk("px_end", gpio_o, 32'h0); chk("px_busy_end", {31'd0, pulse_busy}, 0);

        // watchdog trip after 10 edges, cancelling an active pulse
        wdt_timeout = 10; wdt_kick = 1;
        tick(); wdt_kick = 0;
        for (int i = 1; i <= 9; i++) begin
            pulse_start = (i == 8); pulse_len = 5;
            tick();
        end
        pulse_start = 0;
        chk("wdt_pre", {31'd0, wdt_tripped}, 0);
        chk("wdt_pre_gpio", gpio_o, 32'h5);
        tick();
        chk("wdt_trip", {31'd0, wdt_tripped}, 1);
        chk("wdt_safe", gpio_o, 32'hA5A5_A5A5);
        chk("wdt_pulse_cancel", {31'd0, pulse_busy}, 0);
        safe_value = 32'h0000_1234;
        tick(); chk("safe_follow", gpio_o, 32'h1234);
        wdt_clear = 1;
        tick(); wdt_clear = 0;
        chk("clr_trip", {31'd0, wdt_tripped}, 0);
        chk("clr_gpio", gpio_o, 32'h0);

        // kick on the would-be-trip edge prevents trip
        wdt_kick = 1; tick(); wdt_kick = 0;
        for (int i = 1; i <= 9; i++) tick();
        wdt_kick = 1; tick(); wdt_kick = 0;
        chk("kick_save", {31'd0, wdt_tripped}, 0);
        for (int i = 1; i <= 9; i++) tick();
        chk("kick_pre", {31'd0, wdt_tripped}, 0);
        tick(); chk("kick_trip", {31'd0, wdt_tripped}, 1);
        wr(2'b00, 32'h3);
        chk("trip_wr_st", do_status, 32'h3);
        chk("trip_wr_gpio", gpio_o, 32'h1234);
        wdt_kick = 1; tick(); wdt_kick = 0;
        chk("trip_kick_ignored", {31'd0, wdt_tripped}, 1);
        pulse_start = 1; pulse_len = 4; pulse_mask = 32'hF00;
        tick(); pulse_start = 0;
        chk("trip_pulse_ignored", {31'd0, pulse_busy}, 0);
        wdt_clear = 1; tick(); wdt_clear = 0;
        chk("clr2_trip", {31'd0, wdt_tripped}, 0);
        chk("clr2_gpio", gpio_o, 32'h3);
        chk("clr2_st", do_status, 32'h3);

        // disabled watchdog for 1000 cycles
        wdt_timeout = 0; any_trip = 0;
        for (int i = 0; i < 1000; i++) begin
            tick();
            any_trip |= wdt_tripped;
        end
        chk("t0_no_trip", {31'd0, any_trip}, 0);
        pulse_start = 1; pulse_len = 0; pulse_mask = 32'hFF;
        tick(); pulse_start = 0;
        chk("len0_busy", {31'd0, pulse_busy}, 0);
        chk("len0_gpio", gpio_o, 32'h3);

        // reset mid-pulse
        pulse_start = 1; pulse_len = 5; pulse_mask = 32'h30;
        tick(); pulse_start = 0;
        chk("mid_pulse", gpio_o, 32'h33);
        rst = 1; tick(); rst = 0;
        chk("mrst_gpio", gpio_o, 0);
        chk("mrst_st", do_status, 0);
        chk("mrst_busy", {31'd0, pulse_busy}, 0);
        chk("mrst_trip", {31'd0, wdt_tripped}, 0);
        pulse_start = 1; pulse_len = 1; pulse_mask = 32'h1;
        tick(); pulse_start = 0;
        chk("run_after_rst", gpio_o, 32'h1);
        tick(); chk("len1_end", gpio_o, 32'h0);

        // lowering the timeout below the running count trips on the next edge
        wdt_timeout = 10; wdt_kick = 1; tick(); wdt_kick = 0;
        for (int i = 0; i < 5; i++) tick();
        chk("tchg_pre", {31'd0, wdt_tripped}, 0);
        wdt_timeout = 3;
        tick(); chk("tchg_trip", {31'd0, wdt_tripped}, 1);
        chk("tchg_safe", gpio_o, 32'h1234);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
